// File: rtl/gcn_pkg.sv
// Shared definitions for the GCN accelerator: matrix dimensions, element
// widths, memory map, transformation FSM states and datapath typedefs.
package gcn_pkg;

  // Matrix dimensions
  localparam int FEATURE_ROWS   = 6;
  localparam int FEATURE_COLS   = 96;
  localparam int WEIGHT_ROWS    = 96;
  localparam int WEIGHT_COLS    = 3;

  // Element and result widths
  localparam int IN_DATA_WIDTH  = 5;
  localparam int DOT_PROD_WIDTH = 16;

  // Memory map
  localparam int ADDRESS_WIDTH  = 13;
  localparam int FEATURE_BASE   = 512;

  // Exact width of a full 96-term sum of 5x5-bit products (17 bits)
  localparam int SUM_WIDTH      = 2 * IN_DATA_WIDTH + $clog2(WEIGHT_ROWS);

  // Result row select and the shared column/row fetch counter
  localparam int ROW_SEL_WIDTH  = $clog2(FEATURE_ROWS);
  localparam int COUNT_WIDTH    = $clog2(FEATURE_ROWS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WEIGHT  = 2'd1,
    FEATURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef logic [IN_DATA_WIDTH-1:0]               element_t;
  typedef logic [WEIGHT_ROWS*IN_DATA_WIDTH-1:0]   data_row_t;
  typedef logic [DOT_PROD_WIDTH-1:0]              dot_t;
  typedef logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]  result_row_t;
  typedef logic [COUNT_WIDTH-1:0]                 count_t;

  // Element k of a packed memory word; element 0 sits in the low bits.
  function automatic element_t get_element(input data_row_t row, input int k);
    return row[k*IN_DATA_WIDTH +: IN_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/dot_product.sv
// Combinational 96-term unsigned multiply-accumulate of one feature row
// against one weight column.
// Build option: TRANSFORMATION_SATURATE_EN clamps the result to the all-ones
// value when the exact sum does not fit; otherwise the sum wraps modulo
// 2^DOT_PROD_WIDTH.
module dot_product
  import gcn_pkg::*;
(
  input  data_row_t feature,
  input  data_row_t weight,
  output dot_t      result
);

`ifdef TRANSFORMATION_SATURATE_EN
  // Keep the full exact sum so overflow can be detected.
  localparam int ACC_WIDTH = SUM_WIDTH;
`else
  // Wrapping result: accumulating modulo 2^16 equals truncating the exact sum.
  localparam int ACC_WIDTH = DOT_PROD_WIDTH;
`endif

  logic [ACC_WIDTH-1:0] acc;

  // Sum of element-wise products across the whole vector.
  always_comb begin
    acc = '0;
    for (int k = 0; k < WEIGHT_ROWS; k++) begin
      acc = acc + (ACC_WIDTH'(get_element(feature, k)) *
                   ACC_WIDTH'(get_element(weight, k)));
    end
  end

`ifdef TRANSFORMATION_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] RESULT_MAX = ACC_WIDTH'({DOT_PROD_WIDTH{1'b1}});

  // Clamp to the largest representable result on overflow.
  always_comb begin
    if (acc > RESULT_MAX) result = '1;
    else                  result = acc[DOT_PROD_WIDTH-1:0];
  end
`else
  // Wrapped result is the accumulator itself.
  always_comb begin
    result = acc;
  end
`endif

endmodule

// File: rtl/transformation.sv
// Feature-by-weight transformation stage of the GCN accelerator.
// On start it reads the three weight columns (addresses 0..2) and then the
// six feature rows (FEATURE_BASE..FEATURE_BASE+5) over one wide combinational
// read port, computing one 3-element result row per feature-row cycle.
// Results are held for row-wise combinational readout via read_row.
// Handshake: start is a level request sampled in IDLE; done_trans is high
// while the result matrix is complete, and the stage returns to IDLE only
// once start is dropped. start is ignored while fetching.
// Build option: TRANSFORMATION_SATURATE_EN (see dot_product).
module transformation
  import gcn_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [WEIGHT_ROWS*IN_DATA_WIDTH-1:0]   data_in,
  input  logic [ROW_SEL_WIDTH-1:0]               read_row,
  output logic                                   enable_read,
  output logic [ADDRESS_WIDTH-1:0]               read_address,
  output logic                                   done_trans,
  output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]  FM_WM_Row
);

  localparam count_t LAST_COL = count_t'(WEIGHT_COLS - 1);
  localparam count_t LAST_ROW = count_t'(FEATURE_ROWS - 1);

  state_t    state;
  state_t    state_next;
  count_t    counter;
  data_row_t weight_reg [WEIGHT_COLS];
  dot_t      result_reg [FEATURE_ROWS][WEIGHT_COLS];
  dot_t      dot_out    [WEIGHT_COLS];

  // One MAC per weight column, all fed by the feature row on data_in.
  for (genvar c = 0; c < WEIGHT_COLS; c++) begin : g_dot
    dot_product u_dot (
      .feature (data_in),
      .weight  (weight_reg[c]),
      .result  (dot_out[c])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; the counter tells when the last column/row is fetched.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)               state_next = WEIGHT;
      WEIGHT:  if (counter == LAST_COL) state_next = FEATURE;
      FEATURE: if (counter == LAST_ROW) state_next = DONE;
      DONE:    if (!start)              state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // Moore outputs: memory strobe/address while fetching, done in DONE.
  always_comb begin
    enable_read  = 1'b0;
    read_address = '0;
    done_trans   = 1'b0;
    case (state)
      WEIGHT: begin
        enable_read  = 1'b1;
        read_address = ADDRESS_WIDTH'(counter);
      end
      FEATURE: begin
        enable_read  = 1'b1;
        read_address = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(counter);
      end
      DONE: begin
        done_trans   = 1'b1;
      end
      default: begin
        enable_read  = 1'b0;
      end
    endcase
  end

  // Fetch counter, weight capture and result capture; reset clears everything
  // so an aborted run leaves no partial result behind.
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter <= '0;
      for (int c = 0; c < WEIGHT_COLS; c++) begin
        weight_reg[c] <= '0;
      end
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          result_reg[r][c] <= '0;
        end
      end
    end else begin
      case (state)
        WEIGHT: begin
          for (int c = 0; c < WEIGHT_COLS; c++) begin
            if (counter == count_t'(c)) weight_reg[c] <= data_in;
          end
          counter <= (counter == LAST_COL) ? '0 : counter + 1'b1;
        end
        FEATURE: begin
          for (int r = 0; r < FEATURE_ROWS; r++) begin
            if (counter == count_t'(r)) begin
              for (int c = 0; c < WEIGHT_COLS; c++) begin
                result_reg[r][c] <= dot_out[c];
              end
            end
          end
          counter <= (counter == LAST_ROW) ? '0 : counter + 1'b1;
        end
        default: begin
          counter <= '0;
        end
      endcase
    end
  end

  // Row readout; an out-of-range read_row matches no row and returns zero.
  always_comb begin
    FM_WM_Row = '0;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      if (read_row == ROW_SEL_WIDTH'(r)) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          FM_WM_Row[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = result_reg[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_transformation.sv
// Self-checking bench for the transformation stage: combinational memory
// model, directed runs, and scoreboards for readout and memory addresses.
module tb_transformation;
  import gcn_pkg::*;

  localparam int OBS_W = 2 + ADDRESS_WIDTH + WEIGHT_COLS*DOT_PROD_WIDTH;
`ifdef TRANSFORMATION_SATURATE_EN
  localparam int EXP31 = 65535;
`else
  localparam int EXP31 = 26720;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  data_row_t data_in;
  logic [ROW_SEL_WIDTH-1:0] read_row = '0;
  logic enable_read;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic done_trans;
  result_row_t fm_row;

  always #5 clk = ~clk;

  transformation dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .data_in      (data_in),
    .read_row     (read_row),
    .enable_read  (enable_read),
    .read_address (read_address),
    .done_trans   (done_trans),
    .FM_WM_Row    (fm_row)
  );

  // ---------------- memory model ----------------
  data_row_t mem_weight  [WEIGHT_COLS];
  data_row_t mem_feature [FEATURE_ROWS];

  always_comb begin
    data_in = '0;
    for (int c = 0; c < WEIGHT_COLS; c++)
      if (read_address == ADDRESS_WIDTH'(c)) data_in = mem_weight[c];
    for (int r = 0; r < FEATURE_ROWS; r++)
      if (read_address == ADDRESS_WIDTH'(FEATURE_BASE + r)) data_in = mem_feature[r];
  end

  // ---------------- scoreboard state ----------------
  logic [OBS_W-1:0] exp_q[$];
  string            name_q[$];
  logic [ADDRESS_WIDTH-1:0] addr_q[$];
  logic check_req = 1'b0;
  int checks = 0;
  int errors = 0;

  function automatic logic [OBS_W-1:0] mk_obs(input logic d, input logic e,
                                               input logic [ADDRESS_WIDTH-1:0] a,
                                               input result_row_t r);
    return {d, e, a, r};
  endfunction

  function automatic result_row_t mk_row(input int e0, input int e1, input int e2);
    return {DOT_PROD_WIDTH'(e2), DOT_PROD_WIDTH'(e1), DOT_PROD_WIDTH'(e0)};
  endfunction

  // Readout monitor: compares the observed outputs whenever a check is posted.
  always @(negedge clk) begin
    logic [OBS_W-1:0] e;
    logic [OBS_W-1:0] got;
    string nm;
    if (check_req) begin
      got = {done_trans, enable_read, read_address, fm_row};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got %h, expected nothing queued", got);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL %s: got done=%0b en=%0b addr=%0d row=%h, expected done=%0b en=%0b addr=%0d row=%h",
                   nm, got[OBS_W-1], got[OBS_W-2], got[OBS_W-3 -: ADDRESS_WIDTH],
                   got[WEIGHT_COLS*DOT_PROD_WIDTH-1:0],
                   e[OBS_W-1], e[OBS_W-2], e[OBS_W-3 -: ADDRESS_WIDTH],
                   e[WEIGHT_COLS*DOT_PROD_WIDTH-1:0]);
        end
      end
    end
  end

  // Address monitor: every strobed read must match the next expected address.
  always @(negedge clk) begin
    logic [ADDRESS_WIDTH-1:0] ea;
    if (enable_read === 1'b1) begin
      checks++;
      if (addr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got address %0d, expected no read", read_address);
      end else begin
        ea = addr_q.pop_front();
        if (read_address !== ea) begin
          errors++;
          $display("FAIL read_address: got %0d, expected %0d", read_address, ea);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_obs(input string nm, input int row, input logic [OBS_W-1:0] e);
    read_row = ROW_SEL_WIDTH'(row);
    exp_q.push_back(e);
    name_q.push_back(nm);
    check_req = 1'b1;
    @(posedge clk); #1;
    check_req = 1'b0;
  endtask

  task automatic push_addrs(input int n);
    for (int i = 0; i < n; i++) begin
      if (i < WEIGHT_COLS) addr_q.push_back(ADDRESS_WIDTH'(i));
      else                 addr_q.push_back(ADDRESS_WIDTH'(FEATURE_BASE + i - WEIGHT_COLS));
    end
  endtask

  task automatic fill_uniform(input int f, input int w);
    for (int c = 0; c < WEIGHT_COLS; c++)
      for (int k = 0; k < WEIGHT_ROWS; k++)
        mem_weight[c][k*IN_DATA_WIDTH +: IN_DATA_WIDTH] = IN_DATA_WIDTH'(w);
    for (int r = 0; r < FEATURE_ROWS; r++)
      for (int k = 0; k < WEIGHT_ROWS; k++)
        mem_feature[r][k*IN_DATA_WIDTH +: IN_DATA_WIDTH] = IN_DATA_WIDTH'(f);
  endtask

  task automatic fill_diag();
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      mem_weight[c] = '0;
      mem_weight[c][IN_DATA_WIDTH-1:0] = IN_DATA_WIDTH'(c + 1);
    end
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      mem_feature[r] = '0;
      mem_feature[r][IN_DATA_WIDTH-1:0] = IN_DATA_WIDTH'(r + 1);
    end
  endtask

  // Raise start and count edges until done_trans; expected at the 10th edge.
  task automatic run_to_done(input string nm);
    int lat;
    push_addrs(WEIGHT_COLS + FEATURE_ROWS);
    start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done_trans && lat < 40);
    checks++;
    if (lat != 10 || !done_trans) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges (done=%0b), expected 10 edges", nm, lat, done_trans);
    end
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int found;
    fill_uniform(0, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_obs("reset_row0", 0, mk_obs(1'b0, 1'b0, '0, '0));
    expect_obs("reset_row5", 5, mk_obs(1'b0, 1'b0, '0, '0));
    reset = 1'b1;
    @(posedge clk); #1;

    // All ones: every element 96; start held high keeps DONE with no reads.
    fill_uniform(1, 1);
    run_to_done("ones");
    for (int r = 0; r < FEATURE_ROWS; r++)
      expect_obs("ones_row", r, mk_obs(1'b1, 1'b0, '0, mk_row(96, 96, 96)));
    expect_obs("ones_row6", 6, mk_obs(1'b1, 1'b0, '0, '0));
    drop_start();
    expect_obs("idle_retained", 0, mk_obs(1'b0, 1'b0, '0, mk_row(96, 96, 96)));

    // Single nonzero element per vector: result[r][c] = (r+1)(c+1).
    fill_diag();
    run_to_done("diag");
    for (int r = 0; r < FEATURE_ROWS; r++)
      expect_obs("diag_row", r, mk_obs(1'b1, 1'b0, '0, mk_row(r + 1, 2*(r + 1), 3*(r + 1))));
    expect_obs("diag_row6", 6, mk_obs(1'b1, 1'b0, '0, '0));
    expect_obs("diag_row7", 7, mk_obs(1'b1, 1'b0, '0, '0));
    drop_start();

    // Maximum operands: exact sum 92256 overflows 16 bits.
    fill_uniform(31, 31);
    run_to_done("max");
    for (int r = 0; r < FEATURE_ROWS; r++)
      expect_obs("max_row", r, mk_obs(1'b1, 1'b0, '0, mk_row(EXP31, EXP31, EXP31)));
    drop_start();

    // Reset while feature row 3 is on the bus aborts and clears results.
    fill_uniform(2, 3);
    push_addrs(WEIGHT_COLS + 4);
    start = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(posedge clk); #1;
      if (read_address == ADDRESS_WIDTH'(FEATURE_BASE + 3)) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL abort_reach_row3: got no address %0d, expected it within 20 edges", FEATURE_BASE + 3);
    end
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    expect_obs("abort_row0", 0, mk_obs(1'b0, 1'b0, '0, '0));
    expect_obs("abort_row3", 3, mk_obs(1'b0, 1'b0, '0, '0));
    reset = 1'b1;
    @(posedge clk); #1;

    // Restart after abort gives the full result: 96 * 2 * 3 = 576.
    run_to_done("restart");
    for (int r = 0; r < FEATURE_ROWS; r++)
      expect_obs("restart_row", r, mk_obs(1'b1, 1'b0, '0, mk_row(576, 576, 576)));
    drop_start();
    repeat (2) @(posedge clk);
    #1;

    checks++;
    if (addr_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_items: got %0d reads and %0d checks outstanding, expected 0 and 0",
               addr_q.size(), exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
